// File: rtl/reg_slice_arb.sv
// rtl/reg_slice_arb.sv - round-robin arbiter feeding a one-entry registered output stage
//
// Shares one registered output stage between N valid/ready requesters.
// Each cycle at most one requester is granted. Its beat moves into the
// output register and is presented downstream with its source index.
//
// Optional feature macro: Q_ARB_PACKET_LOCK_EN
//   defined   - packet-locked arbitration: once a multi-beat packet starts,
//               only its requester is eligible until the beat with in_last.
//   undefined - per-beat arbitration: every requester is always eligible.
//
// Parameters:
//   N     - number of requesters (2..16)
//   W     - payload width per beat
//   SRC_W - source index width (derived from N)
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   in_vld   - [N]    per-requester valid
//   in_data  - [N*W]  per-requester payload, requester i at [i*W +: W]
//   in_last  - [N]    per-requester end-of-packet
//   in_rdy   - [N]    per-requester accept, one-hot or zero
//   out_vld  - output register holds a beat
//   out_data - [W]    registered payload
//   out_src  - [SRC_W] requester that supplied the beat
//   out_last - registered end-of-packet
//   out_rdy  - downstream accept

module reg_slice_arb #(
    parameter int N = 4,
    parameter int W = 32,
    localparam int SRC_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_vld,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_rdy,
    output logic             out_vld,
    output logic [W-1:0]     out_data,
    output logic [SRC_W-1:0] out_src,
    output logic             out_last,
    input  logic             out_rdy
);

    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] ptr_nxt;
    logic [SRC_W-1:0] gnt;
    logic [N-1:0]     elig_mask;
    logic [N-1:0]     elig_vld;
    logic             any_elig;
    logic             load;
    logic             accept;
    logic             ptr_upd;
    logic [W-1:0]     sel_data;
    logic             sel_last;
    logic [SRC_W:0]   idx;

    assign load     = ~out_vld | out_rdy;
    assign elig_vld = in_vld & elig_mask;

    // Cyclic scan starting at ptr. Walking offsets from high to low lets the
    // smallest offset (closest to ptr) win with plain overwrites.
    always_comb begin
        gnt      = '0;
        any_elig = 1'b0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SRC_W + 1)'(k);
            if (idx >= (SRC_W + 1)'(N)) begin
                idx = idx - (SRC_W + 1)'(N);
            end
            if (elig_vld[idx[SRC_W-1:0]]) begin
                gnt      = idx[SRC_W-1:0];
                any_elig = 1'b1;
            end
        end
    end

    // Reset gates the handshake so nothing is taken during the reset cycle.
    assign accept = load & any_elig & ~rst;

    always_comb begin
        in_rdy = '0;
        if (accept) begin
            in_rdy[gnt] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SRC_W'(i)) begin
                sel_data = in_data[i*W +: W];
                sel_last = in_last[i];
            end
        end
    end

    assign ptr_nxt = (gnt == SRC_W'(N - 1)) ? '0 : gnt + 1'b1;

`ifdef Q_ARB_PACKET_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SRC_W-1:0] lock_src;
    logic [SRC_W-1:0] lock_src_nxt;
    logic [N-1:0]     lock_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_src <= '0;
        end else begin
            state    <= state_nxt;
            lock_src <= lock_src_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_src_nxt = lock_src;
        case (state)
            IDLE: begin
                if (accept && !sel_last) begin
                    state_nxt    = LOCKED;
                    lock_src_nxt = gnt;
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lock_mask           = '0;
        lock_mask[lock_src] = 1'b1;
    end

    assign elig_mask = (state == LOCKED) ? lock_mask : '1;
    // The arbitration point only closes at the end of a packet.
    assign ptr_upd   = accept & sel_last;
`else
    assign elig_mask = '1;
    assign ptr_upd   = accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_src  <= '0;
            out_last <= 1'b0;
            ptr      <= '0;
        end else begin
            if (load) begin
                out_vld <= accept;
            end
            if (accept) begin
                out_data <= sel_data;
                out_src  <= gnt;
                out_last <= sel_last;
            end
            if (ptr_upd) begin
                ptr <= ptr_nxt;
            end
        end
    end

endmodule
